gray_conv_ctrl: RTL and testbench
=================================

Name: gray_conv_ctrl

Overview:
Sequencer that owns the single-port frame RAM (18-bit address, 8-bit data, 1-cycle registered read, Q=0 when REN low) during RGB-to-grayscale conversion. Per pixel it reads the R, G and B planes and writes Y = (77R+150G+29B+128)>>8 to the Y plane. When idle it arbitrates the RAM to a host port for image load and readback. It sits between the top-level control/host interface and the RAM instance.

Parameters:
ADDR_W, 18, RAM address width
DATA_W, 8, pixel width (fixed at 8; the coefficient math assumes 8)
IMG_PIXELS, 65536, pixels per plane (1..2^16)
R_BASE, 0, R plane base address
G_BASE, 65536, G plane base address
B_BASE, 131072, B plane base address
Y_BASE, 196608, Y plane base address

Ports:
CLK  in  1  clock; all state changes on posedge
RST_N  in  1  asynchronous active-low reset
start  in  1  begin conversion; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE is exited
done  out  1  one-cycle pulse in DONE
pix_idx  out  16  index of the pixel being processed
host_req  in  1  host requests a RAM access; held until granted
host_wen  in  1  1 = write, 0 = read
host_a  in  ADDR_W  host address
host_d  in  DATA_W  host write data
host_gnt  out  1  access granted this cycle (combinational)
host_q  out  DATA_W  read data; valid the cycle after a granted read (ram_q passthrough)
ram_ren  out  1  to RAM REN
ram_wen  out  1  to RAM WEN
ram_a  out  ADDR_W  to RAM A
ram_d  out  DATA_W  to RAM D
ram_q  in  DATA_W  from RAM Q

Behaviour:
- Reset: state=IDLE, pix_idx=0, r_reg=g_reg=0. busy=0, done=0, host_gnt=0. ram_ren, ram_wen, ram_a and ram_d are forced to 0 while RST_N is low, regardless of host_req. Reset mid-conversion aborts immediately; the Y plane is left partially written and there is no resume.
- States: IDLE, RD_R, RD_G, RD_B, WR_Y, DONE. RAM outputs are decoded combinationally from the state, pix_idx and the host inputs.
- IDLE: if start, go to RD_R with pix_idx=0 and host_gnt=0. Start has priority over host_req in the same cycle. Otherwise host_gnt=host_req, ram_ren=host_req&~host_wen, ram_wen=host_req&host_wen, ram_a=host_a, ram_d=host_d. With no request, all RAM outputs are 0.
- RD_R: ren=1, a=R_BASE+pix_idx, then RD_G.
- RD_G: ren=1, a=G_BASE+pix_idx, r_reg<=ram_q, then RD_B.
- RD_B: ren=1, a=B_BASE+pix_idx, g_reg<=ram_q, then WR_Y.
- WR_Y: wen=1, ren=0, a=Y_BASE+pix_idx, d=gray(r_reg, g_reg, ram_q).
  - If pix_idx==IMG_PIXELS-1, go to DONE.
  - Otherwise pix_idx++ and go to RD_R.
- DONE: done=1, all RAM outputs 0, then IDLE. pix_idx holds its final value until the next start.
- Arithmetic: 16-bit unsigned sum 77R+150G+29B+128 (maximum 65408, no overflow); Y = sum[15:8]. No saturation is needed; all-255 input gives 255.
- Addresses: base+pix_idx, ADDR_W bits, truncated. Plane overlap is a configuration error and is not checked.
- Timing: 4 cycles per pixel. The start-accept edge to the first cycle of done is 4*IMG_PIXELS cycles. busy is low in IDLE only.
- start while busy is ignored. host_req outside IDLE gets host_gnt=0; the host must hold its signals. ren and wen are never high together.

Test Plan:
- Reset: assert RST_N=0 mid-RD_G with host_req=1 -> all outputs 0 immediately, state IDLE after release, next start converts from pixel 0.
- Single pixel, IMG_PIXELS=1, R/G/B=255/0/0 -> Y=77; R/G/B=0/255/0 -> Y=149; 0/0/255 -> 29; 255/255/255 -> 255; 100/150/200 -> 141. done pulses 4 cycles after start accept.
- Full frame, IMG_PIXELS=16, random planes -> Y plane matches the reference model, exactly one done pulse, wen asserted exactly 16 times, non-Y addresses never written.
- Host arbitration: host_req=1 held during conversion -> host_gnt=0 throughout; granted on the first IDLE cycle after done; host read of Y_BASE+3 returns converted pixel 3 on host_q the next cycle.
- Simultaneous start and host_req in IDLE -> conversion starts, host_gnt=0, ram_wen=0 that cycle.
- start pulsed while busy -> ignored, total cycles unchanged, single done.

Source files
------------

// File: rtl/gray_conv_ctrl.sv
// RGB-to-grayscale sequencer that owns the single-port frame RAM during conversion
// and hands the RAM to the host port while idle.
module gray_conv_ctrl #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8,
  parameter int IMG_PIXELS = 65536,
  parameter int R_BASE     = 0,
  parameter int G_BASE     = 65536,
  parameter int B_BASE     = 131072,
  parameter int Y_BASE     = 196608
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pix_idx,
  input  logic              host_req,
  input  logic              host_wen,
  input  logic [ADDR_W-1:0] host_a,
  input  logic [DATA_W-1:0] host_d,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_q,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_R = 3'd1,
    RD_G = 3'd2,
    RD_B = 3'd3,
    WR_Y = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       pix_idx_nxt;
  logic [DATA_W-1:0] r_reg, g_reg;

  logic              gnt_c, ren_c, wen_c;
  logic [ADDR_W-1:0] a_c;
  logic [DATA_W-1:0] d_c;

  logic [15:0]       y_sum;
  logic [DATA_W-1:0] y_val;
  logic              last_pix;
  logic [ADDR_W-1:0] pix_off;

  // 77+150+29 = 256, so the sum tops out at 65408 and never needs saturation
  assign y_sum = 16'd77  * 16'(r_reg)
               + 16'd150 * 16'(g_reg)
               + 16'd29  * 16'(ram_q)
               + 16'd128;
  assign y_val    = DATA_W'(y_sum[15:8]);
  assign last_pix = (pix_idx == 16'(IMG_PIXELS - 1));
  assign pix_off  = ADDR_W'(pix_idx);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      pix_idx <= '0;
      r_reg   <= '0;
      g_reg   <= '0;
    end else begin
      state   <= state_nxt;
      pix_idx <= pix_idx_nxt;
      if (state == RD_G) r_reg <= ram_q;
      if (state == RD_B) g_reg <= ram_q;
    end
  end

  always_comb begin
    state_nxt   = state;
    pix_idx_nxt = pix_idx;
    gnt_c       = 1'b0;
    ren_c       = 1'b0;
    wen_c       = 1'b0;
    a_c         = '0;
    d_c         = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = RD_R;
          pix_idx_nxt = '0;
        end else if (host_req) begin
          gnt_c = 1'b1;
          ren_c = ~host_wen;
          wen_c = host_wen;
          a_c   = host_a;
          d_c   = host_d;
        end
      end
      RD_R: begin
        ren_c     = 1'b1;
        a_c       = ADDR_W'(R_BASE) + pix_off;
        state_nxt = RD_G;
      end
      RD_G: begin
        ren_c     = 1'b1;
        a_c       = ADDR_W'(G_BASE) + pix_off;
        state_nxt = RD_B;
      end
      RD_B: begin
        ren_c     = 1'b1;
        a_c       = ADDR_W'(B_BASE) + pix_off;
        state_nxt = WR_Y;
      end
      WR_Y: begin
        // B arrives on ram_q this cycle and feeds the sum directly
        wen_c = 1'b1;
        a_c   = ADDR_W'(Y_BASE) + pix_off;
        d_c   = y_val;
        if (last_pix) begin
          state_nxt = DONE;
        end else begin
          pix_idx_nxt = pix_idx + 16'd1;
          state_nxt   = RD_R;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM strobes are held off combinationally while reset is asserted
  assign host_gnt = RST_N & gnt_c;
  assign ram_ren  = RST_N & ren_c;
  assign ram_wen  = RST_N & wen_c;
  assign ram_a    = RST_N ? a_c : '0;
  assign ram_d    = RST_N ? d_c : '0;
  assign host_q   = ram_q;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_gray_conv_ctrl.sv
// Bench for gray_conv_ctrl: a 1-pixel instance for the coefficient vectors and a
// 16-pixel instance for frame, arbitration and reset cases, each with its own RAM.
module tb_gray_conv_ctrl;

  localparam int AW = 18;
  localparam int DW = 8;
  localparam int RB = 0;
  localparam int GB = 65536;
  localparam int BB = 131072;
  localparam int YB = 196608;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          start [2];
  logic          host_req [2];
  logic          host_wen [2];
  logic [AW-1:0] host_a [2];
  logic [DW-1:0] host_d [2];
  logic          busy [2];
  logic          done [2];
  logic [15:0]   pix_idx [2];
  logic          host_gnt [2];
  logic [DW-1:0] host_q [2];
  logic          ram_ren [2];
  logic          ram_wen [2];
  logic [AW-1:0] ram_a [2];
  logic [DW-1:0] ram_d [2];
  logic [DW-1:0] ram_q0 = '0;
  logic [DW-1:0] ram_q1 = '0;

  logic [DW-1:0] mem0 [0:(1<<AW)-1];
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  int wr_cnt1 = 0;
  int bad_wr1 = 0;
  int n_tests = 0;
  int n_fail  = 0;

  gray_conv_ctrl #(.IMG_PIXELS(1)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .pix_idx(pix_idx[0]), .host_req(host_req[0]), .host_wen(host_wen[0]),
    .host_a(host_a[0]), .host_d(host_d[0]), .host_gnt(host_gnt[0]), .host_q(host_q[0]),
    .ram_ren(ram_ren[0]), .ram_wen(ram_wen[0]), .ram_a(ram_a[0]), .ram_d(ram_d[0]),
    .ram_q(ram_q0)
  );

  gray_conv_ctrl #(.IMG_PIXELS(16)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .pix_idx(pix_idx[1]), .host_req(host_req[1]), .host_wen(host_wen[1]),
    .host_a(host_a[1]), .host_d(host_d[1]), .host_gnt(host_gnt[1]), .host_q(host_q[1]),
    .ram_ren(ram_ren[1]), .ram_wen(ram_wen[1]), .ram_a(ram_a[1]), .ram_d(ram_d[1]),
    .ram_q(ram_q1)
  );

  always_ff @(posedge clk) begin
    ram_q0 <= ram_ren[0] ? mem0[ram_a[0]] : '0;
    if (ram_wen[0]) mem0[ram_a[0]] <= ram_d[0];
  end

  always_ff @(posedge clk) begin
    ram_q1 <= ram_ren[1] ? mem1[ram_a[1]] : '0;
    if (ram_wen[1]) begin
      mem1[ram_a[1]] <= ram_d[1];
      wr_cnt1 <= wr_cnt1 + 1;
      if (busy[1] && (int'(ram_a[1]) < YB || int'(ram_a[1]) >= YB + 16))
        bad_wr1 <= bad_wr1 + 1;
    end
  end

  typedef struct {
    int r;
    int g;
    int b;
    int y;
  } vec_t;

  vec_t vecs [5];
  int   exp_y [16];

  function automatic int gray(input int r, input int g, input int b);
    return (77 * r + 150 * g + 29 * b + 128) >> 8;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic host_write(input int s, input int a, input int d);
    @(negedge clk);
    host_req[s] = 1'b1; host_wen[s] = 1'b1;
    host_a[s] = AW'(a); host_d[s] = DW'(d);
    @(negedge clk);
    host_req[s] = 1'b0; host_wen[s] = 1'b0;
  endtask

  task automatic host_read(input int s, input int a, output int q);
    @(negedge clk);
    host_req[s] = 1'b1; host_wen[s] = 1'b0; host_a[s] = AW'(a);
    @(negedge clk);
    host_req[s] = 1'b0;
    #1 q = int'(host_q[s]);
  endtask

  initial begin
    int q, n, dcnt, first, gbad, w0, b0;

    vecs[0] = '{255,   0,   0,  77};
    vecs[1] = '{  0, 255,   0, 149};
    vecs[2] = '{  0,   0, 255,  29};
    vecs[3] = '{255, 255, 255, 255};
    vecs[4] = '{100, 150, 200, 141};

    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0; host_req[s] = 1'b0; host_wen[s] = 1'b0;
      host_a[s] = '0; host_d[s] = '0;
    end
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_pix_idx", pix_idx[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single-pixel vectors; the last one also raises a host write alongside start
    for (int i = 0; i < 5; i++) begin
      host_write(0, RB, vecs[i].r);
      host_write(0, GB, vecs[i].g);
      host_write(0, BB, vecs[i].b);
      @(negedge clk);
      start[0] = 1'b1;
      if (i == 4) begin
        host_req[0] = 1'b1; host_wen[0] = 1'b1;
        host_a[0] = AW'(YB); host_d[0] = 8'hAA;
      end
      #1;
      if (i == 4) begin
        check("start_prio_gnt", host_gnt[0], 0);
        check("start_prio_wen", ram_wen[0], 0);
      end
      n = 0;
      @(negedge clk);
      start[0] = 1'b0; host_req[0] = 1'b0; host_wen[0] = 1'b0;
      #1;
      check("busy_after_start", busy[0], 1);
      while (!done[0] && n < 20) begin
        @(negedge clk); #1; n++;
      end
      check("done_latency_1px", n, 4);
      @(negedge clk); #1;
      check("done_single_pulse", done[0], 0);
      check("busy_low_idle", busy[0], 0);
      host_read(0, YB, q);
      check($sformatf("y_vec%0d", i), q, vecs[i].y);
    end

    // 16-pixel frame preload
    for (int p = 0; p < 16; p++) begin
      int r, g, b;
      r = int'($urandom_range(0, 255));
      g = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      exp_y[p] = gray(r, g, b);
      host_write(1, RB + p, r);
      host_write(1, GB + p, g);
      host_write(1, BB + p, b);
    end

    // Abort mid-RD_G of pixel 2 with a host request pending
    @(negedge clk);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("pre_rst_pix_idx", pix_idx[1], 2);
    host_req[1] = 1'b1; host_wen[1] = 1'b1;
    host_a[1] = AW'(RB); host_d[1] = 8'h55;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy[1], 0);
    check("rst_mid_gnt", host_gnt[1], 0);
    check("rst_mid_ren", ram_ren[1], 0);
    check("rst_mid_wen", ram_wen[1], 0);
    check("rst_mid_a", ram_a[1], 0);
    check("rst_mid_d", ram_d[1], 0);
    check("rst_mid_pix_idx", pix_idx[1], 0);
    @(negedge clk);
    host_req[1] = 1'b0; host_wen[1] = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_idle", busy[1], 0);

    // Full frame with a held host read of Y+3 and a stray start while busy
    w0 = wr_cnt1; b0 = bad_wr1;
    @(negedge clk);
    start[1] = 1'b1;
    host_req[1] = 1'b1; host_wen[1] = 1'b0; host_a[1] = AW'(YB + 3);
    #1;
    check("frame_start_gnt", host_gnt[1], 0);
    dcnt = 0; first = -1; gbad = 0;
    for (int k = 0; k < 72; k++) begin
      @(negedge clk);
      start[1] = (k == 10);
      #1;
      if (k == 0) begin
        check("frame_first_idx", pix_idx[1], 0);
        check("frame_first_addr", ram_a[1], RB);
      end
      if (busy[1] && host_gnt[1]) gbad++;
      if (done[1]) begin
        dcnt++;
        if (first < 0) first = k;
      end
      if (first >= 0 && k == first + 1) check("gnt_after_done", host_gnt[1], 1);
      if (first >= 0 && k == first + 2) begin
        check("host_q_y3", host_q[1], exp_y[3]);
        host_req[1] = 1'b0;
      end
    end
    check("frame_done_cycle", first, 64);
    check("frame_done_count", dcnt, 1);
    check("gnt_while_busy", gbad, 0);
    check("frame_wen_count", wr_cnt1 - w0, 16);
    check("frame_non_y_writes", bad_wr1 - b0, 0);
    check("frame_final_idx", pix_idx[1], 15);
    for (int p = 0; p < 16; p++) begin
      host_read(1, YB + p, q);
      check($sformatf("frame_y%0d", p), q, exp_y[p]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
